mem_access_stage: RTL

//  Parametrised MEM pipeline stage between EX/MEM and MEM/WB for the 5-stage RV32 core.

---
 rtl/mem_access_stage.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage RV32 core: load/store via a dmem req/ready handshake, with pass-through for non-memory ops.
// Optional macro MISALIGN_TRAP_EN traps misaligned half/word accesses instead of issuing them.
module mem_access_stage #(
  parameter int ADDR_W       = 32,
  parameter int RD_W         = 5,
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       rs2_data,
  input  logic [RD_W-1:0]   rd,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic [RD_W-1:0]   rd_out,
  output logic              reg_write_out,
  output logic [31:0]       wb_data,
  output logic              err,
  output logic              misalign
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  // Fields of the in-flight memory op needed once the response arrives.
  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            reg_write;
    logic            store;
    logic [2:0]      funct3;
    logic [31:0]     addr;
  } op_t;

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [31:0]       wait_q, wait_d;
  logic              dmem_req_d, dmem_we_d;
  logic [ADDR_W-1:0] dmem_addr_d;
  logic [31:0]       dmem_wdata_d;
  logic [3:0]        dmem_be_d;
  logic              wb_valid_d, reg_write_out_d, err_d, misalign_d, misalign_q;
  logic [RD_W-1:0]   rd_out_d;
  logic [31:0]       wb_data_d;

  logic        is_mem, f3_illegal, mis_addr, timeout_hit;
  logic [31:0] store_data, load_data;
  logic [3:0]  store_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Stall comes from the state register only, so no comb path from dmem_ready.
  assign stall       = (state_q == ACCESS);
  assign is_mem      = mem_read | mem_write;
  assign f3_illegal  = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (mem_write && funct3[2]);
  assign timeout_hit = (WAIT_TIMEOUT != 0) && (wait_q == 32'(WAIT_TIMEOUT - 1));
  assign misalign    = misalign_q;

`ifdef MISALIGN_TRAP_EN
  assign mis_addr = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                    ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));
`else
  assign mis_addr = 1'b0;
`endif

  always_comb begin
    store_data = rs2_data;
    store_be   = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        store_data = {4{rs2_data[7:0]}};
        store_be   = 4'b0001 << alu_result[1:0];
      end
      2'b01: begin
        store_data = {2{rs2_data[15:0]}};
        store_be   = 4'b0011 << {alu_result[1], 1'b0};
      end
      default: ;
    endcase
  end

  assign ld_byte = dmem_rdata[{op_q.addr[1:0], 3'b000} +: 8];
  assign ld_half = op_q.addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    load_data = dmem_rdata;
    case (op_q.funct3)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {24'b0, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_data = {16'b0, ld_half};
      default: load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    wait_d          = wait_q;
    dmem_req_d      = dmem_req;
    dmem_we_d       = dmem_we;
    dmem_addr_d     = dmem_addr;
    dmem_wdata_d    = dmem_wdata;
    dmem_be_d       = dmem_be;
    wb_valid_d      = 1'b0;
    err_d           = 1'b0;
    misalign_d      = 1'b0;
    rd_out_d        = rd_out;
    reg_write_out_d = reg_write_out;
    wb_data_d       = wb_data;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rd_out_d  = rd;
          wb_data_d = alu_result;
          if (!is_mem) begin
            wb_valid_d      = 1'b1;
            reg_write_out_d = reg_write;
          end else if (f3_illegal) begin
            wb_valid_d      = 1'b1;
            err_d           = 1'b1;
            reg_write_out_d = 1'b0;
          end else if (mis_addr) begin
            wb_valid_d      = 1'b1;
            misalign_d      = 1'b1;
            reg_write_out_d = 1'b0;
          end else begin
            op_d         = '{rd: rd, reg_write: reg_write, store: mem_write,
                             funct3: funct3, addr: alu_result};
            wait_d       = '0;
            dmem_req_d   = 1'b1;
            dmem_we_d    = mem_write;
            dmem_addr_d  = {alu_result[ADDR_W-1:2], 2'b00};
            dmem_wdata_d = mem_write ? store_data : 32'h0;
            dmem_be_d    = mem_write ? store_be : 4'b0000;
            state_d      = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (dmem_ready || timeout_hit) begin
          dmem_req_d      = 1'b0;
          dmem_we_d       = 1'b0;
          dmem_be_d       = 4'b0000;
          wb_valid_d      = 1'b1;
          rd_out_d        = op_q.rd;
          wb_data_d       = op_q.addr;
          reg_write_out_d = 1'b0;
          state_d         = IDLE;
          if (dmem_ready) begin
            if (!op_q.store) begin
              wb_data_d       = load_data;
              reg_write_out_d = op_q.reg_write;
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      op_q          <= '0;
      wait_q        <= '0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      dmem_be       <= '0;
      wb_valid      <= 1'b0;
      rd_out        <= '0;
      reg_write_out <= 1'b0;
      wb_data       <= '0;
      err           <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      wait_q        <= wait_d;
      dmem_req      <= dmem_req_d;
      dmem_we       <= dmem_we_d;
      dmem_addr     <= dmem_addr_d;
      dmem_wdata    <= dmem_wdata_d;
      dmem_be       <= dmem_be_d;
      wb_valid      <= wb_valid_d;
      rd_out        <= rd_out_d;
      reg_write_out <= reg_write_out_d;
      wb_data       <= wb_data_d;
      err           <= err_d;
      misalign_q    <= misalign_d;
    end
  end

endmodule
